// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: shared state encoding and byte helpers for the UART
// packet scheduler.
package uart_tx_sched_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_HDR       = 3'd1,
    ST_WAIT_HDR  = 3'd2,
    ST_DATA      = 3'd3,
    ST_WAIT_DATA = 3'd4,
    ST_CSUM      = 3'd5,
    ST_WAIT_CSUM = 3'd6
  } state_e;

  // Header byte: base pattern with the requester id in its low bits.
  function automatic logic [7:0] hdr_byte(input logic [7:0] base, input logic [7:0] id);
    return base | id;
  endfunction

  // One step of the running XOR checksum.
  function automatic logic [7:0] xor_acc(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. The first request at or after
// ptr_i (wrapping at N) wins; gnt_o is one-hot, id_o its encoded index.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] id_o,
  output logic           valid_o
);

  // Scan N positions starting at the pointer and keep the first hit.
  always_comb begin : p_scan
    int             raw;
    logic [IDW-1:0] idx;
    gnt_o   = '0;
    id_o    = '0;
    valid_o = 1'b0;
    raw     = 0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      raw = int'(ptr_i) + i;
      if (raw >= N) begin
        idx = IDW'(raw - N);
      end else begin
        idx = IDW'(raw);
      end
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        id_o       = idx;
        valid_o    = 1'b1;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: packet-level round-robin scheduler sharing one UART_TX among
// NUM_REQ byte-stream requesters. Each packet is header, payload up to the
// byte flagged last, then (with UART_TX_SCHED_CSUM_EN defined) an XOR
// checksum byte. All outputs are registered.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int          NUM_REQ     = 4,
  parameter logic [7:0]  HDR_BASE    = 8'hA0,
  parameter int          GAP_TIMEOUT = 4096
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  input  logic [NUM_REQ-1:0]   i_Req_Last,
  output logic [NUM_REQ-1:0]   o_Req_Ready,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_TX_Valid,
  output logic [7:0]           o_TX_Byte,
  input  logic                 i_TX_Busy,
  input  logic                 i_TX_Done,
  output logic                 o_Abort,
  output logic                 o_Pkt_Done
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int GW  = (GAP_TIMEOUT > 2) ? $clog2(GAP_TIMEOUT) : 1;
  localparam logic [GW-1:0]  GAP_MAX = GW'(GAP_TIMEOUT - 1);
  localparam logic [IDW-1:0] ID_MAX  = IDW'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic [IDW-1:0]       id_q, id_d;
  logic [IDW-1:0]       rr_q, rr_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 last_q, last_d;
  logic                 abort_q, abort_d;
  logic                 pkt_done_q, pkt_done_d;
`ifdef UART_TX_SCHED_CSUM_EN
  logic [7:0]           csum_q, csum_d;
`endif

  logic [7:0]           req_byte_s [NUM_REQ];
  logic [NUM_REQ-1:0]   arb_gnt_s;
  logic [IDW-1:0]       arb_id_s;
  logic                 arb_valid_s;
  logic [IDW-1:0]       rr_next_s;
  logic                 cur_valid_s;
  logic                 cur_last_s;
  logic [7:0]           cur_byte_s;
  logic [7:0]           hdr_s;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_byte_s[k] = i_Req_Byte[8*k +: 8];
  end

  rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_arb (
    .req_i   (i_Req_Valid),
    .ptr_i   (rr_q),
    .gnt_o   (arb_gnt_s),
    .id_o    (arb_id_s),
    .valid_o (arb_valid_s)
  );

  assign cur_valid_s = i_Req_Valid[id_q];
  assign cur_last_s  = i_Req_Last[id_q];
  assign cur_byte_s  = req_byte_s[id_q];
  assign hdr_s       = hdr_byte(HDR_BASE, 8'(id_q));
  // The requester just serviced drops to lowest priority.
  assign rr_next_s   = (id_q == ID_MAX) ? '0 : id_q + IDW'(1);

  // State and output registers; reset clears everything and returns to IDLE.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      ready_q    <= '0;
      id_q       <= '0;
      rr_q       <= '0;
      gap_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      last_q     <= 1'b0;
      abort_q    <= 1'b0;
      pkt_done_q <= 1'b0;
`ifdef UART_TX_SCHED_CSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ready_q    <= ready_d;
      id_q       <= id_d;
      rr_q       <= rr_d;
      gap_q      <= gap_d;
      tx_valid_q <= tx_valid_d;
      tx_byte_q  <= tx_byte_d;
      last_q     <= last_d;
      abort_q    <= abort_d;
      pkt_done_q <= pkt_done_d;
`ifdef UART_TX_SCHED_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Next-state logic: arbitration, byte issue, waiting on UART done, gap abort.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ready_d    = '0;
    id_d       = id_q;
    rr_d       = rr_q;
    gap_d      = gap_q;
    tx_valid_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    last_d     = last_q;
    abort_d    = 1'b0;
    pkt_done_d = 1'b0;
`ifdef UART_TX_SCHED_CSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_valid_s) begin
          grant_d = arb_gnt_s;
          id_d    = arb_id_s;
          gap_d   = '0;
`ifdef UART_TX_SCHED_CSUM_EN
          csum_d  = 8'h00;
`endif
          state_d = ST_HDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (!i_TX_Busy) begin
          tx_valid_d = 1'b1;
          tx_byte_d  = hdr_s;
`ifdef UART_TX_SCHED_CSUM_EN
          csum_d     = xor_acc(csum_q, hdr_s);
`endif
          state_d    = ST_WAIT_HDR;
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_WAIT_HDR: begin
        if (i_TX_Done) begin
          gap_d   = '0;
          state_d = ST_DATA;
        end else begin
          state_d = ST_WAIT_HDR;
        end
      end
      ST_DATA: begin
        if (cur_valid_s && !i_TX_Busy) begin
          ready_d    = grant_q;
          tx_valid_d = 1'b1;
          tx_byte_d  = cur_byte_s;
          last_d     = cur_last_s;
          gap_d      = '0;
`ifdef UART_TX_SCHED_CSUM_EN
          csum_d     = xor_acc(csum_q, cur_byte_s);
`endif
          state_d    = ST_WAIT_DATA;
        end else if (gap_q == GAP_MAX) begin
          // Already-sent bytes stay on the wire; only the grant is dropped.
          abort_d = 1'b1;
          grant_d = '0;
          rr_d    = rr_next_s;
          gap_d   = '0;
          state_d = ST_IDLE;
        end else if (!cur_valid_s) begin
          gap_d = gap_q + GW'(1);
        end else begin
          gap_d = gap_q;
        end
      end
      ST_WAIT_DATA: begin
        if (i_TX_Done && !last_q) begin
          state_d = ST_DATA;
        end else if (i_TX_Done) begin
`ifdef UART_TX_SCHED_CSUM_EN
          state_d    = ST_CSUM;
`else
          pkt_done_d = 1'b1;
          grant_d    = '0;
          rr_d       = rr_next_s;
          state_d    = ST_IDLE;
`endif
        end else begin
          state_d = ST_WAIT_DATA;
        end
      end
`ifdef UART_TX_SCHED_CSUM_EN
      ST_CSUM: begin
        if (!i_TX_Busy) begin
          tx_valid_d = 1'b1;
          tx_byte_d  = csum_q;
          state_d    = ST_WAIT_CSUM;
        end else begin
          state_d = ST_CSUM;
        end
      end
      ST_WAIT_CSUM: begin
        if (i_TX_Done) begin
          pkt_done_d = 1'b1;
          grant_d    = '0;
          rr_d       = rr_next_s;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_WAIT_CSUM;
        end
      end
`endif
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_Req_Ready = ready_q;
  assign o_Grant     = grant_q;
  assign o_TX_Valid  = tx_valid_q;
  assign o_TX_Byte   = tx_byte_q;
  assign o_Abort     = abort_q;
  assign o_Pkt_Done  = pkt_done_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed scoreboard bench. Expected UART bytes are queued
// with the stimulus; a monitor pops and compares on every o_TX_Valid.
module tb_uart_tx_sched;

  localparam int NR    = 4;
  localparam int FRAME = 12;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [8*NR-1:0] req_byte = '0;
  logic [NR-1:0] req_last = '0;
  logic [NR-1:0] req_ready;
  logic [NR-1:0] grant;
  logic          tx_valid;
  logic [7:0]    tx_byte;
  logic          tx_busy = 1'b0;
  logic          tx_done = 1'b0;
  logic          abort_p;
  logic          pkt_done_p;

  int chk = 0;
  int err = 0;
  int n_pkt = 0;
  int n_abort = 0;
  int n_ready [NR];
  int cyc = 0;
  int last_done_cyc = 0;
  int abort_gap = 0;
  int tx_cnt = 0;
  logic [7:0] tx_lat = 8'h00;

  logic [7:0] exp_q [$];
  logic [8:0] rq0 [$];
  logic [8:0] rq1 [$];
  logic [8:0] rq2 [$];
  logic [8:0] rq3 [$];

  uart_tx_sched #(.NUM_REQ(NR), .HDR_BASE(8'hA0), .GAP_TIMEOUT(4096)) dut (
    .i_Clock     (clk),
    .i_Rst_L     (rst_l),
    .i_Req_Valid (req_valid),
    .i_Req_Byte  (req_byte),
    .i_Req_Last  (req_last),
    .o_Req_Ready (req_ready),
    .o_Grant     (grant),
    .o_TX_Valid  (tx_valid),
    .o_TX_Byte   (tx_byte),
    .i_TX_Busy   (tx_busy),
    .i_TX_Done   (tx_done),
    .o_Abort     (abort_p),
    .o_Pkt_Done  (pkt_done_p)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] head(input int k);
    case (k)
      0: return (rq0.size() != 0) ? {1'b1, rq0[0]} : 10'd0;
      1: return (rq1.size() != 0) ? {1'b1, rq1[0]} : 10'd0;
      2: return (rq2.size() != 0) ? {1'b1, rq2[0]} : 10'd0;
      default: return (rq3.size() != 0) ? {1'b1, rq3[0]} : 10'd0;
    endcase
  endfunction

  task automatic rq_push(input int k, input logic [7:0] b, input logic last);
    case (k)
      0: rq0.push_back({last, b});
      1: rq1.push_back({last, b});
      2: rq2.push_back({last, b});
      default: rq3.push_back({last, b});
    endcase
  endtask

  task automatic rq_pop(input int k);
    logic [8:0] d;
    case (k)
      0: d = rq0.pop_front();
      1: d = rq1.pop_front();
      2: d = rq2.pop_front();
      default: d = rq3.pop_front();
    endcase
  endtask

  task automatic exp(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic exp_csum(input logic [7:0] b);
`ifdef UART_TX_SCHED_CSUM_EN
    exp_q.push_back(b);
`endif
  endtask

  // Requester models and UART_TX model (busy one cycle after valid, done at frame end).
  initial begin
    logic [9:0] h;
    forever begin
      @(negedge clk);
      if (!rst_l) begin
        tx_cnt  = 0;
        tx_busy = 1'b0;
        tx_done = 1'b0;
      end else begin
        tx_done = 1'b0;
        if (tx_cnt > 0) begin
          chk++;
          if (tx_byte !== tx_lat) begin
            err++;
            $display("FAIL tx_byte_stable: got %h, required %h during frame", tx_byte, tx_lat);
          end
          tx_cnt--;
          tx_busy = (tx_cnt > 0);
          tx_done = (tx_cnt == 0);
        end
        if (tx_valid) begin
          chk++;
          if (tx_cnt != 0 || tx_busy) begin
            err++;
            $display("FAIL tx_overlap: o_TX_Valid=1 with busy=%b frame_left=%0d, required idle UART", tx_busy, tx_cnt);
          end
          tx_cnt = FRAME;
          tx_lat = tx_byte;
        end
      end
      for (int k = 0; k < NR; k++) begin
        if (req_ready[k]) begin
          h = head(k);
          if (h[9]) rq_pop(k);
          else begin
            chk++;
            err++;
            $display("FAIL ready_without_valid: requester %0d got ready=1, required 0", k);
          end
        end
      end
      for (int k = 0; k < NR; k++) begin
        h = head(k);
        req_valid[k]        = h[9];
        req_last[k]         = h[8];
        req_byte[8*k +: 8]  = h[7:0];
      end
    end
  end

  // Monitor: pops expected bytes on each o_TX_Valid, counts pulses.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_done) last_done_cyc = cyc;
      if (pkt_done_p) n_pkt++;
      if (abort_p) begin
        n_abort++;
        abort_gap = cyc - last_done_cyc;
      end
      if (req_ready != '0) begin
        chk++;
        for (int k = 0; k < NR; k++) if (req_ready[k]) n_ready[k]++;
        if (((req_ready & ~grant) != '0) || !$onehot(req_ready)) begin
          err++;
          $display("FAIL ready_vs_grant: ready=%b grant=%b, required one-hot within grant", req_ready, grant);
        end
      end
      if (tx_valid) begin
        chk++;
        if (exp_q.size() == 0) begin
          err++;
          $display("FAIL tx_byte_unexpected: got %h, required no byte", tx_byte);
        end else begin
          e = exp_q.pop_front();
          if (tx_byte !== e) begin
            err++;
            $display("FAIL tx_byte: got %h, required %h", tx_byte, e);
          end
        end
      end
    end
  end

  task automatic check_zero(input string name);
    chk++;
    if (grant !== '0 || tx_valid !== 1'b0 || tx_byte !== 8'h00 || req_ready !== '0 ||
        abort_p !== 1'b0 || pkt_done_p !== 1'b0) begin
      err++;
      $display("FAIL %s: grant=%b valid=%b byte=%h ready=%b abort=%b done=%b, required all 0",
               name, grant, tx_valid, tx_byte, req_ready, abort_p, pkt_done_p);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_l = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset_outputs");
    rst_l = 1'b1;
  endtask

  task automatic wait_quiet(input int max, input string name);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    while (n < max && !ok) begin
      @(negedge clk);
      n++;
      ok = (exp_q.size() == 0) && (grant == '0) && (tx_cnt == 0);
    end
    repeat (2) @(negedge clk);
    chk++;
    if (!ok) begin
      err++;
      $display("FAIL %s_timeout: %0d bytes still expected after %0d cycles, required 0", name, exp_q.size(), n);
    end
  endtask

  task automatic check_count(input string name, input int got, input int req);
    chk++;
    if (got != req) begin
      err++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  initial begin
    int p0, a0;
    int r0 [NR];
    for (int k = 0; k < NR; k++) n_ready[k] = 0;

    // T1: single requester 1, packet {55, 3C last}; checksum A1^55^3C = C8.
    do_reset();
    p0 = n_pkt; a0 = n_abort;
    exp(8'hA1); exp(8'h55); exp(8'h3C); exp_csum(8'hC8);
    rq_push(1, 8'h55, 1'b0); rq_push(1, 8'h3C, 1'b1);
    wait_quiet(2000, "t1");
    check_count("t1_pkt_done", n_pkt - p0, 1);
    check_count("t1_abort", n_abort - a0, 0);
    check_count("t1_grant_cleared", int'(grant), 0);

    // T2: requesters 0 and 2 from reset; 0 first, then 2.
    do_reset();
    p0 = n_pkt;
    exp(8'hA0); exp(8'h11); exp(8'h12); exp_csum(8'hA3);
    exp(8'hA2); exp(8'h21); exp_csum(8'h83);
    rq_push(0, 8'h11, 1'b0); rq_push(0, 8'h12, 1'b1);
    rq_push(2, 8'h21, 1'b1);
    wait_quiet(2000, "t2");
    check_count("t2_pkt_done", n_pkt - p0, 2);
    // Pointer now 3: requester 3 beats requester 0.
    p0 = n_pkt;
    exp(8'hA3); exp(8'hE3); exp_csum(8'h40);
    exp(8'hA0); exp(8'hE1); exp_csum(8'h41);
    rq_push(0, 8'hE1, 1'b1); rq_push(3, 8'hE3, 1'b1);
    wait_quiet(2000, "t2b");
    check_count("t2b_pkt_done", n_pkt - p0, 2);

    // T3: all four continuously valid with 1-byte packets: 0,1,2,3,0,1,2,3.
    do_reset();
    p0 = n_pkt;
    for (int k = 0; k < NR; k++) r0[k] = n_ready[k];
    for (int k = 0; k < NR; k++) begin
      exp(8'hA0 | 8'(k)); exp(8'h30 + 8'(k)); exp_csum(8'h90);
    end
    for (int k = 0; k < NR; k++) begin
      exp(8'hA0 | 8'(k)); exp(8'h40 + 8'(k)); exp_csum(8'hE0);
    end
    for (int k = 0; k < NR; k++) begin
      rq_push(k, 8'h30 + 8'(k), 1'b1); rq_push(k, 8'h40 + 8'(k), 1'b1);
    end
    wait_quiet(4000, "t3");
    check_count("t3_pkt_done", n_pkt - p0, 8);
    for (int k = 0; k < NR; k++) check_count("t3_ready_pulses", n_ready[k] - r0[k], 2);

    // T4: requester 0 stalls after its first byte; gap timeout aborts, 1 follows.
    p0 = n_pkt; a0 = n_abort;
    exp(8'hA0); exp(8'h77);
    exp(8'hA1); exp(8'h99); exp_csum(8'h38);
    rq_push(0, 8'h77, 1'b0);
    rq_push(1, 8'h99, 1'b1);
    wait_quiet(6000, "t4");
    check_count("t4_abort", n_abort - a0, 1);
    check_count("t4_pkt_done", n_pkt - p0, 1);
    chk++;
    if (abort_gap < 4094 || abort_gap > 4100) begin
      err++;
      $display("FAIL t4_abort_gap: got %0d cycles, required about 4097", abort_gap);
    end

    // T5: reset in the middle of requester 2's payload.
    p0 = n_pkt;
    exp(8'hA2); exp(8'h01);
    rq_push(2, 8'h01, 1'b0); rq_push(2, 8'h02, 1'b0);
    rq_push(2, 8'h03, 1'b0); rq_push(2, 8'h04, 1'b1);
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check_count("t5_bytes_before_reset", exp_q.size(), 0);
    end
    repeat (3) @(negedge clk);
    rst_l = 1'b0;
    rq2.delete();
    @(negedge clk);
    check_zero("t5_reset_mid_packet");
    @(negedge clk);
    rst_l = 1'b1;
    exp(8'hA0); exp(8'h5A); exp_csum(8'hFA);
    exp(8'hA2); exp(8'h6B); exp_csum(8'hC9);
    rq_push(0, 8'h5A, 1'b1); rq_push(2, 8'h6B, 1'b1);
    wait_quiet(2000, "t5");
    check_count("t5_pkt_done", n_pkt - p0, 2);

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
